// File: rtl/color_detect_seq.sv
// Filter sequencer, synchronised edge counter and dominant-colour classifier for a TCS3200-type sensor.
// Optional build macro: CLEAR_CHANNEL_EN (adds a clear-filter window and the clear_cnt output).
module color_detect_seq #(
    parameter int WINDOW  = 500,
    parameter int SETTLE  = 4,
    parameter int CNT_W   = 16,
    parameter int MIN_CNT = 16
) (
    input  logic             clk_1MHz,
    input  logic             rst,
    input  logic             enable,
    input  logic             cs_out,
    output logic [1:0]       filter,
    output logic [1:0]       color,
    output logic             color_valid,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
`ifdef CLEAR_CHANNEL_EN
    output logic [CNT_W-1:0] clear_cnt,
`endif
    output logic [2:0]       dbg_state
);

    localparam int PH_W    = $clog2(SETTLE + WINDOW + 1);
    localparam int PH_LAST = SETTLE + WINDOW - 1;
    localparam logic [CNT_W:0] MIN_V = (CNT_W + 1)'(MIN_CNT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_G      = 3'd1,
        S_R      = 3'd2,
        S_B      = 3'd3,
        S_C      = 3'd4,
        S_DECIDE = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PH_W-1:0]  r_phase;
    logic [1:0]       r_sync;
    logic             r_prev;
    logic [CNT_W-1:0] r_wr, r_wg, r_wb;
    logic [CNT_W-1:0] r_red, r_green, r_blue;
    logic [1:0]       r_color;
    logic             r_color_valid;
    logic             w_edge, w_in_window, w_last, w_count;
    logic [1:0]       w_win_color, w_decided;
    logic [CNT_W-1:0] w_gate;
`ifdef CLEAR_CHANNEL_EN
    logic [CNT_W-1:0] r_wc, r_clear;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_edge      = r_sync[1] & ~r_prev;
        w_in_window = r_phase >= PH_W'(SETTLE);
        w_last      = r_phase == PH_W'(PH_LAST);
        w_count     = w_edge & w_in_window;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_next = S_G;
            S_G:      if (!enable) w_next = S_IDLE; else if (w_last) w_next = S_R;
            S_R:      if (!enable) w_next = S_IDLE; else if (w_last) w_next = S_B;
`ifdef CLEAR_CHANNEL_EN
            S_B:      if (!enable) w_next = S_IDLE; else if (w_last) w_next = S_C;
            S_C:      if (!enable) w_next = S_IDLE; else if (w_last) w_next = S_DECIDE;
`else
            S_B:      if (!enable) w_next = S_IDLE; else if (w_last) w_next = S_DECIDE;
`endif
            S_DECIDE: w_next = enable ? S_G : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // S2S3 codes: red=0, blue=1, clear/idle=2, green=3
    always_comb begin
        filter = 2'd2;
        case (r_state)
            S_G:     filter = 2'd3;
            S_R:     filter = 2'd0;
            S_B:     filter = 2'd1;
            default: filter = 2'd2;
        endcase
    end

    // Ties resolve red > blue > green
    always_comb begin
        w_win_color = 2'd2;
        w_gate      = r_wg;
        if (r_wr >= r_wg && r_wr >= r_wb) begin
            w_win_color = 2'd1;
            w_gate      = r_wr;
        end else if (r_wb >= r_wg) begin
            w_win_color = 2'd3;
            w_gate      = r_wb;
        end
`ifdef CLEAR_CHANNEL_EN
        w_gate = r_wc;
`endif
        w_decided = ({1'b0, w_gate} < MIN_V) ? 2'd0 : w_win_color;
    end

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_phase       <= '0;
            r_sync        <= '0;
            r_prev        <= 1'b0;
            r_wr          <= '0;
            r_wg          <= '0;
            r_wb          <= '0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_color       <= 2'd0;
            r_color_valid <= 1'b0;
`ifdef CLEAR_CHANNEL_EN
            r_wc          <= '0;
            r_clear       <= '0;
`endif
        end else begin
            r_state       <= w_next;
            r_sync        <= {r_sync[0], cs_out};
            r_prev        <= r_sync[1];
            r_color_valid <= 1'b0;

            if (w_next != r_state)
                r_phase <= '0;
            else if (r_state != S_IDLE)
                r_phase <= r_phase + 1'b1;

            if (w_next == S_G && r_state != S_G) r_wg <= '0;
            else if (r_state == S_G && w_count) r_wg <= sat_inc(r_wg);
            if (w_next == S_R && r_state != S_R) r_wr <= '0;
            else if (r_state == S_R && w_count) r_wr <= sat_inc(r_wr);
            if (w_next == S_B && r_state != S_B) r_wb <= '0;
            else if (r_state == S_B && w_count) r_wb <= sat_inc(r_wb);
`ifdef CLEAR_CHANNEL_EN
            if (w_next == S_C && r_state != S_C) r_wc <= '0;
            else if (r_state == S_C && w_count) r_wc <= sat_inc(r_wc);
`endif

            if (r_state == S_DECIDE) begin
                r_red         <= r_wr;
                r_green       <= r_wg;
                r_blue        <= r_wb;
                r_color       <= w_decided;
                r_color_valid <= 1'b1;
`ifdef CLEAR_CHANNEL_EN
                r_clear       <= r_wc;
`endif
            end
        end
    end

    assign color       = r_color;
    assign color_valid = r_color_valid;
    assign red_cnt     = r_red;
    assign green_cnt   = r_green;
    assign blue_cnt    = r_blue;
    assign dbg_state   = r_state;
`ifdef CLEAR_CHANNEL_EN
    assign clear_cnt   = r_clear;
`endif

endmodule

// File: tb/tb_color_detect_seq.sv
// Directed bench for color_detect_seq: default instance (a) plus a small-window 4-bit instance (b).
`timescale 1ns/1ps
module tb_color_detect_seq;
  localparam int A_W = 500, A_S = 4, A_CW = 16, A_MIN = 16;
  localparam int B_W = 60,  B_S = 8, B_CW = 4,  B_MIN = 1;
  localparam int A_L = A_S + A_W;
  localparam int B_L = B_S + B_W;
`ifdef CLEAR_CHANNEL_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 3;
`endif

  logic clk = 1'b0;
  always #500 clk = ~clk;

  logic rst = 1'b1;
  logic en_a = 1'b0, cs_a = 1'b0, en_b = 1'b0, cs_b = 1'b0;
  logic [1:0] filt_a, col_a, filt_b, col_b;
  logic val_a, val_b;
  logic [A_CW-1:0] rc_a, gc_a, bc_a;
  logic [B_CW-1:0] rc_b, gc_b, bc_b;
  logic [2:0] dbg_a, dbg_b;
`ifdef CLEAR_CHANNEL_EN
  logic [A_CW-1:0] cc_a;
  logic [B_CW-1:0] cc_b;
`endif

  color_detect_seq #(.WINDOW(A_W), .SETTLE(A_S), .CNT_W(A_CW), .MIN_CNT(A_MIN)) u_a (
    .clk_1MHz(clk), .rst(rst), .enable(en_a), .cs_out(cs_a),
    .filter(filt_a), .color(col_a), .color_valid(val_a),
    .red_cnt(rc_a), .green_cnt(gc_a), .blue_cnt(bc_a),
`ifdef CLEAR_CHANNEL_EN
    .clear_cnt(cc_a),
`endif
    .dbg_state(dbg_a)
  );

  color_detect_seq #(.WINDOW(B_W), .SETTLE(B_S), .CNT_W(B_CW), .MIN_CNT(B_MIN)) u_b (
    .clk_1MHz(clk), .rst(rst), .enable(en_b), .cs_out(cs_b),
    .filter(filt_b), .color(col_b), .color_valid(val_b),
    .red_cnt(rc_b), .green_cnt(gc_b), .blue_cnt(bc_b),
`ifdef CLEAR_CHANNEL_EN
    .clear_cnt(cc_b),
`endif
    .dbg_state(dbg_b)
  );

  int checks = 0;
  int failures = 0;
  bit pat [0:4095];
  int obs_lat, obs_pulses, obs_filt_end;
  int obs_filt [0:3];

  // One frame on instance inst. Channel order in time is G, R, B (, C); pat[j+1] is cs_out in cycle j.
  task automatic run_frame(input int inst, input int rn, input int gn, input int bn, input int cn,
                           input int sn, input int abort_at, input bit keep_en);
    int l, s, last_n;
    int n_cnt [0:3];
    logic v, c;
    logic [1:0] f;
    l = (inst == 1) ? B_L : A_L;
    s = (inst == 1) ? B_S : A_S;
    n_cnt[0] = gn; n_cnt[1] = rn; n_cnt[2] = bn; n_cnt[3] = cn;
    for (int i = 0; i < 4096; i++) pat[i] = 1'b0;
    for (int k = 0; k < NWIN; k++) begin
      for (int i = 0; i < sn; i++) pat[k*l + 2*i] = 1'b1;
      for (int i = 0; i < n_cnt[k]; i++) pat[k*l + s + 3 + 2*i] = 1'b1;
    end
    last_n = (abort_at >= 0) ? NWIN*l + 20 : NWIN*l + 4;
    obs_lat = -1; obs_pulses = 0; obs_filt_end = -1;
    for (int k = 0; k < 4; k++) obs_filt[k] = -1;
    @(negedge clk);
    if (inst == 1) begin en_b = 1'b1; cs_b = pat[0]; end
    else begin en_a = 1'b1; cs_a = pat[0]; end
    for (int n = 0; n <= last_n; n++) begin
      @(posedge clk); #1;
      v = (inst == 1) ? val_b : val_a;
      f = (inst == 1) ? filt_b : filt_a;
      if (v) begin
        obs_pulses++;
        if (obs_lat < 0) obs_lat = n;
      end
      for (int k = 0; k < NWIN; k++) if (n == k*l + l/2) obs_filt[k] = int'(f);
      if ((abort_at >= 0 && n == abort_at + 1) || (abort_at < 0 && n == NWIN*l + 1))
        obs_filt_end = int'(f);
      @(negedge clk);
      c = (abort_at < 0 || n < abort_at) ? pat[n+1] : 1'b0;
      if (inst == 1) cs_b = c; else cs_a = c;
      if (n == abort_at || (abort_at < 0 && n == NWIN*l && !keep_en)) begin
        if (inst == 1) en_b = 1'b0; else en_a = 1'b0;
      end
    end
    en_a = 1'b0; en_b = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({filt_a, col_a, val_a, dbg_a} !== {2'd2, 2'd0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_a_ctrl: got filt=%0d col=%0d val=%0d st=%0d expected 2 0 0 0", filt_a, col_a, val_a, dbg_a);
    end
    checks++;
    if ({rc_a, gc_a, bc_a} !== 48'd0) begin
      failures++;
      $display("FAIL reset_a_cnts: got %0d %0d %0d expected 0 0 0", rc_a, gc_a, bc_a);
    end
    checks++;
    if ({filt_b, col_b, val_b, rc_b, gc_b, bc_b} !== {2'd2, 2'd0, 1'b0, 12'd0}) begin
      failures++;
      $display("FAIL reset_b: got filt=%0d col=%0d val=%0d cnt=%0d/%0d/%0d expected 2 0 0 0/0/0", filt_b, col_b, val_b, rc_b, gc_b, bc_b);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int exp_f [0:3];
    exp_f[0] = 3; exp_f[1] = 0; exp_f[2] = 1; exp_f[3] = 2;
    run_frame(0, 40, 25, 10, 20, 0, -1, 1'b0);
    checks++;
    if (obs_lat !== NWIN*A_L + 1) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected %0d", obs_lat, NWIN*A_L + 1);
    end
    checks++;
    if (obs_pulses !== 1) begin
      failures++;
      $display("FAIL basic_pulses: got %0d expected 1", obs_pulses);
    end
    for (int k = 0; k < NWIN; k++) begin
      checks++;
      if (obs_filt[k] !== exp_f[k]) begin
        failures++;
        $display("FAIL basic_filter_%0d: got %0d expected %0d", k, obs_filt[k], exp_f[k]);
      end
    end
    checks++;
    if (obs_filt_end !== 2) begin
      failures++;
      $display("FAIL basic_idle_after_decide: got filter %0d expected 2", obs_filt_end);
    end
    checks++;
    if ({col_a, rc_a, gc_a, bc_a} !== {2'd1, 16'd40, 16'd25, 16'd10}) begin
      failures++;
      $display("FAIL basic_result: got col=%0d r=%0d g=%0d b=%0d expected 1 40 25 10", col_a, rc_a, gc_a, bc_a);
    end
`ifdef CLEAR_CHANNEL_EN
    checks++;
    if (cc_a !== 16'd20) begin
      failures++;
      $display("FAIL basic_clear_cnt: got %0d expected 20", cc_a);
    end
`endif
  endtask

  task automatic test_ties;
    run_frame(0, 30, 10, 30, 20, 0, -1, 1'b0);
    checks++;
    if ({col_a, rc_a, gc_a, bc_a} !== {2'd1, 16'd30, 16'd10, 16'd30}) begin
      failures++;
      $display("FAIL tie_red_blue: got col=%0d r=%0d g=%0d b=%0d expected 1 30 10 30", col_a, rc_a, gc_a, bc_a);
    end
    run_frame(0, 5, 30, 30, 20, 0, -1, 1'b1);
    checks++;
    if ({col_a, rc_a, gc_a, bc_a} !== {2'd3, 16'd5, 16'd30, 16'd30}) begin
      failures++;
      $display("FAIL tie_blue_green: got col=%0d r=%0d g=%0d b=%0d expected 3 5 30 30", col_a, rc_a, gc_a, bc_a);
    end
    checks++;
    if (obs_filt_end !== 3) begin
      failures++;
      $display("FAIL back_to_back_green: got filter %0d expected 3", obs_filt_end);
    end
  endtask

  task automatic test_abort;
    run_frame(0, 9, 9, 9, 9, 0, 2*A_L + A_L/2, 1'b0);
    checks++;
    if (obs_filt_end !== 2) begin
      failures++;
      $display("FAIL abort_filter: got %0d expected 2", obs_filt_end);
    end
    checks++;
    if (obs_pulses !== 0) begin
      failures++;
      $display("FAIL abort_no_valid: got %0d pulses expected 0", obs_pulses);
    end
    checks++;
    if ({col_a, rc_a, gc_a, bc_a} !== {2'd3, 16'd5, 16'd30, 16'd30}) begin
      failures++;
      $display("FAIL abort_hold: got col=%0d r=%0d g=%0d b=%0d expected 3 5 30 30", col_a, rc_a, gc_a, bc_a);
    end
  endtask

  task automatic test_weak;
    run_frame(0, 5, 5, 5, 5, 0, -1, 1'b0);
    checks++;
    if (obs_pulses !== 1) begin
      failures++;
      $display("FAIL weak_pulses: got %0d expected 1", obs_pulses);
    end
    checks++;
    if ({col_a, rc_a, gc_a, bc_a} !== {2'd0, 16'd5, 16'd5, 16'd5}) begin
      failures++;
      $display("FAIL weak_result: got col=%0d r=%0d g=%0d b=%0d expected 0 5 5 5", col_a, rc_a, gc_a, bc_a);
    end
  endtask

  task automatic test_settle;
    run_frame(1, 7, 3, 5, 4, 3, -1, 1'b0);
    checks++;
    if (obs_lat !== NWIN*B_L + 1) begin
      failures++;
      $display("FAIL settle_latency: got %0d expected %0d", obs_lat, NWIN*B_L + 1);
    end
    checks++;
    if ({col_b, rc_b, gc_b, bc_b} !== {2'd1, 4'd7, 4'd3, 4'd5}) begin
      failures++;
      $display("FAIL settle_result: got col=%0d r=%0d g=%0d b=%0d expected 1 7 3 5", col_b, rc_b, gc_b, bc_b);
    end
`ifdef CLEAR_CHANNEL_EN
    checks++;
    if (cc_b !== 4'd4) begin
      failures++;
      $display("FAIL settle_clear_cnt: got %0d expected 4", cc_b);
    end
`endif
  endtask

  task automatic test_saturation;
    logic [1:0] exp_col;
`ifdef CLEAR_CHANNEL_EN
    exp_col = 2'd0;
`else
    exp_col = 2'd1;
`endif
    run_frame(1, 20, 0, 0, 0, 0, -1, 1'b0);
    checks++;
    if ({col_b, rc_b, gc_b, bc_b} !== {exp_col, 4'd15, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL saturation: got col=%0d r=%0d g=%0d b=%0d expected %0d 15 0 0", col_b, rc_b, gc_b, bc_b, exp_col);
    end
  endtask

  task automatic test_reset_running;
    int pulses;
    @(negedge clk);
    en_a = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      cs_a = ~cs_a;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({filt_a, col_a, val_a, dbg_a, rc_a, gc_a, bc_a} !== {2'd2, 2'd0, 1'b0, 3'd0, 48'd0}) begin
      failures++;
      $display("FAIL reset_running_a: got filt=%0d col=%0d val=%0d st=%0d cnt=%0d/%0d/%0d expected 2 0 0 0 0/0/0",
               filt_a, col_a, val_a, dbg_a, rc_a, gc_a, bc_a);
    end
    checks++;
    if ({filt_b, col_b, dbg_b, rc_b} !== {2'd2, 2'd0, 3'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_running_b: got filt=%0d col=%0d st=%0d r=%0d expected 2 0 0 0", filt_b, col_b, dbg_b, rc_b);
    end
    @(negedge clk);
    rst = 1'b0; en_a = 1'b0; cs_a = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (val_a) pulses++;
    end
    checks++;
    if (pulses !== 0 || col_a !== 2'd0) begin
      failures++;
      $display("FAIL reset_no_publish: got pulses=%0d col=%0d expected 0 0", pulses, col_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_abort();
    test_weak();
    test_settle();
    test_saturation();
    test_reset_running();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
